// File: rtl/hemaia_clk_rst_pkg.sv
// Shared types and elaboration helpers for the HeMAiA clock/reset controller.
package hemaia_clk_rst_pkg;

  // Divisor-change sequencer states.
  typedef enum logic [2:0] {
    SEQ_INIT,
    SEQ_IDLE,
    SEQ_ASSERT_RST,
    SEQ_UPDATE,
    SEQ_WAIT_SWITCH,
    SEQ_RELEASE,
    SEQ_DONE
  } seq_state_e;

  // Worst-case divider switch window: adoption at counter wrap plus output retiming.
  function automatic int switch_cycles(input int div_width);
    return 2 << div_width;
  endfunction

  // Width of a domain index, never narrower than one bit.
  function automatic int dom_idx_width(input int num_domains);
    return (num_domains > 1) ? $clog2(num_domains) : 1;
  endfunction

endpackage

// File: rtl/hemaia_clk_seq_timer.sv
// Shared down-counter for the sequencer's timed states; holds at zero.
module hemaia_clk_seq_timer #(
  parameter int              Width      = 6,
  parameter logic [Width-1:0] ResetValue = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load,
  input  logic [Width-1:0] value,
  input  logic             tick,
  output logic             zero
);

  logic [Width-1:0] count_q;

  // Load has priority over tick; counting stops once zero is reached.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= ResetValue;
    end else if (load) begin
      count_q <= value;
    end else if (tick && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/hemaia_clk_div_sequencer.sv
// Sequences glitch-safe divisor changes for the per-domain clock dividers and
// provides their power-on reset release.
module hemaia_clk_div_sequencer
  import hemaia_clk_rst_pkg::*;
#(
  parameter int   NumDomains       = 4,
  parameter int   MaxDivisionWidth = 4,
  parameter int   DefaultDivision  = 1,
  parameter int   SettleCycles     = 4,
  localparam int  DomIdxW          = dom_idx_width(NumDomains)
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic                                   cfg_valid_i,
  output logic                                   cfg_ready_o,
  input  logic [DomIdxW-1:0]                     cfg_domain_i,
  input  logic [MaxDivisionWidth-1:0]            cfg_divisor_i,
  output logic [NumDomains*MaxDivisionWidth-1:0] divisor_o,
  output logic [NumDomains-1:0]                  divisor_valid_o,
  output logic [NumDomains-1:0]                  domain_rst_no,
  output logic                                   busy_o,
  output logic                                   done_o,
  output logic                                   err_o
);

  localparam int SwitchCycles = switch_cycles(MaxDivisionWidth);
  localparam int CntW         = $clog2(SwitchCycles + SettleCycles + 1);
  localparam logic [CntW-1:0] InitCount   = CntW'(SwitchCycles + SettleCycles - 1);
  localparam logic [CntW-1:0] SettleCount = CntW'(SettleCycles - 1);
  localparam logic [CntW-1:0] SwitchCount = CntW'(SwitchCycles - 1);
  localparam logic [MaxDivisionWidth-1:0] DefaultDiv = MaxDivisionWidth'(DefaultDivision);
  localparam logic DefaultRuns = (DefaultDivision != 0);

  seq_state_e                  state_q, state_d;
  logic                        tmr_load, tmr_tick, tmr_zero;
  logic [CntW-1:0]             tmr_value;
  logic                        dom_bad, accept;
  logic                        init_release, enter_update, enter_done;
  logic [DomIdxW-1:0]          dom_q;
  logic [MaxDivisionWidth-1:0] div_q;

  // An index can only be out of range when the index field can encode one.
  if ((1 << DomIdxW) > NumDomains) begin : g_dom_check
    assign dom_bad = (cfg_domain_i >= DomIdxW'(NumDomains));
  end else begin : g_dom_full
    assign dom_bad = 1'b0;
  end

  assign accept       = (state_q == SEQ_IDLE) && cfg_valid_i && !dom_bad;
  assign init_release = (state_q == SEQ_INIT) && (state_d == SEQ_IDLE);
  assign enter_update = (state_d == SEQ_UPDATE);
  assign enter_done   = (state_d == SEQ_DONE);
  assign cfg_ready_o  = (state_q == SEQ_IDLE);
  assign busy_o       = (state_q != SEQ_IDLE);

  hemaia_clk_seq_timer #(
    .Width      (CntW),
    .ResetValue (InitCount)
  ) u_timer (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .load  (tmr_load),
    .value (tmr_value),
    .tick  (tmr_tick),
    .zero  (tmr_zero)
  );

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= SEQ_INIT;
    else       state_q <= state_d;
  end

  // Next-state and timer control; each timed state loads its length minus one on entry.
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d   = state_q;
    tmr_load  = 1'b0;
    tmr_tick  = 1'b0;
    tmr_value = SettleCount;
    unique case (state_q)
      SEQ_INIT: begin
        tmr_tick = 1'b1;
        if (tmr_zero) state_d = SEQ_IDLE;
      end
      SEQ_IDLE: begin
        if (accept) begin
          state_d  = SEQ_ASSERT_RST;
          tmr_load = 1'b1;
        end
      end
      SEQ_ASSERT_RST: begin
        tmr_tick = 1'b1;
        if (tmr_zero) state_d = SEQ_UPDATE;
      end
      SEQ_UPDATE: begin
        state_d   = SEQ_WAIT_SWITCH;
        tmr_load  = 1'b1;
        tmr_value = SwitchCount;
      end
      SEQ_WAIT_SWITCH: begin
        tmr_tick = 1'b1;
        if (tmr_zero) begin
          state_d  = SEQ_RELEASE;
          tmr_load = 1'b1;
        end
      end
      SEQ_RELEASE: begin
        tmr_tick = 1'b1;
        if (tmr_zero) state_d = SEQ_DONE;
      end
      SEQ_DONE: state_d = SEQ_IDLE;
      default:  state_d = SEQ_INIT;
    endcase
  end

  // Request latch plus the done and reject pulses.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      dom_q  <= '0;
      div_q  <= '0;
      done_o <= 1'b0;
      err_o  <= 1'b0;
    end else begin
      if (accept) begin
        dom_q <= cfg_domain_i;
        div_q <= cfg_divisor_i;
      end
      done_o <= enter_done;
      err_o  <= (state_q == SEQ_IDLE) && cfg_valid_i && dom_bad;
    end
  end

  for (genvar g = 0; g < NumDomains; g++) begin : g_dom
    logic                        hit_new, hit_lat;
    logic [MaxDivisionWidth-1:0] div_r;
    logic                        valid_r, rst_n_r;

    assign hit_new = (cfg_domain_i == DomIdxW'(g));
    assign hit_lat = (dom_q == DomIdxW'(g));

    // Per-domain divisor, update pulse and domain reset; untouched unless this domain is targeted.
    // NOTE: these are individual flops feeding live dividers, so each resets to the dividers' own reset state.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        div_r   <= DefaultDiv;
        valid_r <= 1'b0;
        rst_n_r <= 1'b0;
      end else begin
        valid_r <= enter_update && hit_lat;
        if (enter_update && hit_lat) div_r <= div_q;
        if (init_release)              rst_n_r <= DefaultRuns;
        else if (accept && hit_new)    rst_n_r <= 1'b0;
        else if (enter_done && hit_lat) rst_n_r <= (div_q != '0);
      end
    end

    assign divisor_o[g*MaxDivisionWidth +: MaxDivisionWidth] = div_r;
    assign divisor_valid_o[g] = valid_r;
    assign domain_rst_no[g]   = rst_n_r;
  end

endmodule

// File: tb/tb_hemaia_clk_div_sequencer.sv
// Directed bench for hemaia_clk_div_sequencer: power-on release, divisor
// changes, gating, out-of-range rejection, back-to-back requests and mid-sequence reset.
module tb_hemaia_clk_div_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_valid, cfg_valid3;
  logic [1:0]  cfg_domain;
  logic [3:0]  cfg_divisor;

  logic        cfg_ready, busy, done, err;
  logic [15:0] divisor;
  logic [3:0]  divisor_valid, domain_rst_n;

  logic        cfg_ready3, busy3, done3, err3;
  logic [11:0] divisor3;
  logic [2:0]  divisor_valid3, domain_rst_n3;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_div;
  logic [3:0]  exp_rst;

  always #5 clk = ~clk;

  hemaia_clk_div_sequencer dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .cfg_valid_i     (cfg_valid),
    .cfg_ready_o     (cfg_ready),
    .cfg_domain_i    (cfg_domain),
    .cfg_divisor_i   (cfg_divisor),
    .divisor_o       (divisor),
    .divisor_valid_o (divisor_valid),
    .domain_rst_no   (domain_rst_n),
    .busy_o          (busy),
    .done_o          (done),
    .err_o           (err)
  );

  // Three domains leave index 3 encodable but out of range.
  hemaia_clk_div_sequencer #(.NumDomains(3)) dut3 (
    .clk_i           (clk),
    .rst_i           (rst),
    .cfg_valid_i     (cfg_valid3),
    .cfg_ready_o     (cfg_ready3),
    .cfg_domain_i    (cfg_domain),
    .cfg_divisor_i   (cfg_divisor),
    .divisor_o       (divisor3),
    .divisor_valid_o (divisor_valid3),
    .domain_rst_no   (domain_rst_n3),
    .busy_o          (busy3),
    .done_o          (done3),
    .err_o           (err3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance n cycles; inputs are driven and outputs sampled on the falling edge.
  task automatic adv(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Issue a request at the current cycle (cycle 0) and check its full timeline.
  task automatic run_seq(input int d, input logic [3:0] nd, input bit hold);
    logic [3:0]  rst_during, rst_after, pulse;
    logic [15:0] div_after;
    pulse      = 4'b0001 << d;
    rst_during = exp_rst & ~pulse;
    rst_after  = (nd != 4'd0) ? (rst_during | pulse) : rst_during;
    div_after  = exp_div;
    div_after[d*4 +: 4] = nd;

    cfg_domain  = 2'(d);
    cfg_divisor = nd;
    cfg_valid   = 1'b1;
    chk("seq_ready_c0", cfg_ready, 1);
    adv(1);
    if (!hold) cfg_valid = 1'b0;
    chk("seq_rst_fall_c1", domain_rst_n, rst_during);
    chk("seq_not_ready_c1", cfg_ready, 0);
    chk("seq_busy_c1", busy, 1);
    chk("seq_div_hold_c1", divisor, exp_div);
    adv(3);
    chk("seq_no_pulse_c4", divisor_valid, 0);
    chk("seq_div_hold_c4", divisor, exp_div);
    adv(1);
    chk("seq_pulse_c5", divisor_valid, pulse);
    chk("seq_div_c5", divisor, div_after);
    adv(1);
    chk("seq_pulse_end_c6", divisor_valid, 0);
    adv(35);
    chk("seq_no_done_c41", done, 0);
    chk("seq_rst_held_c41", domain_rst_n, rst_during);
    adv(1);
    chk("seq_done_c42", done, 1);
    chk("seq_rst_c42", domain_rst_n, rst_after);
    chk("seq_not_ready_c42", cfg_ready, 0);
    adv(1);
    chk("seq_ready_c43", cfg_ready, 1);
    chk("seq_done_end_c43", done, 0);
    exp_div = div_after;
    exp_rst = rst_after;
  endtask

  initial begin
    rst         = 1'b1;
    cfg_valid   = 1'b0;
    cfg_valid3  = 1'b0;
    cfg_domain  = 2'd0;
    cfg_divisor = 4'd0;
    exp_div     = 16'h1111;
    exp_rst     = 4'hF;

    // Reset values.
    adv(2);
    chk("rst_ready", cfg_ready, 0);
    chk("rst_busy", busy, 1);
    chk("rst_domain_rst", domain_rst_n, 0);
    chk("rst_divisor", divisor, 16'h1111);
    chk("rst_pulses", {err, done, divisor_valid}, 0);

    // Power-on INIT: 36 cycles of held reset, then release together.
    rst = 1'b0;
    adv(35);
    chk("init_ready_c35", cfg_ready, 0);
    chk("init_rst_c35", domain_rst_n, 0);
    chk("init_no_pulse_c35", divisor_valid, 0);
    adv(1);
    chk("init_ready_c36", cfg_ready, 1);
    chk("init_busy_c36", busy, 0);
    chk("init_rst_c36", domain_rst_n, 4'hF);
    chk("init_div_c36", divisor, 16'h1111);
    chk("init3_rst_c36", domain_rst_n3, 3'h7);

    // Domain 2 to divisor 5.
    run_seq(2, 4'd5, 1'b0);
    chk("d2_final_div", divisor, 16'h1511);

    // Back-to-back with valid held: identical second sequence accepted at cycle 43.
    run_seq(0, 4'd7, 1'b1);
    run_seq(0, 4'd7, 1'b0);
    chk("b2b_final_div", divisor, 16'h1517);

    // Gate domain 1, confirm it stays in reset, then ungate it.
    run_seq(1, 4'd0, 1'b0);
    adv(3);
    chk("gate_rst_stays", domain_rst_n, 4'b1101);
    run_seq(1, 4'd3, 1'b0);
    chk("ungate_rst", domain_rst_n, 4'hF);
    chk("ungate_div", divisor, 16'h1537);

    // Out-of-range index on the three-domain instance.
    cfg_domain  = 2'd3;
    cfg_divisor = 4'd2;
    cfg_valid3  = 1'b1;
    adv(1);
    cfg_valid3  = 1'b0;
    chk("err_pulse_c1", err3, 1);
    chk("err_ready_c1", cfg_ready3, 1);
    chk("err_no_update_c1", divisor_valid3, 0);
    chk("err_rst_untouched", domain_rst_n3, 3'h7);
    adv(1);
    chk("err_pulse_end_c2", err3, 0);
    chk("err_div_untouched", divisor3, 12'h111);

    // Reset at cycle 20 of a sequence discards the partial change.
    cfg_domain  = 2'd3;
    cfg_divisor = 4'd9;
    cfg_valid   = 1'b1;
    adv(1);
    cfg_valid   = 1'b0;
    adv(4);
    chk("midrst_div_applied_c5", divisor, 16'h9537);
    adv(15);
    rst = 1'b1;
    #1;
    chk("midrst_div", divisor, 16'h1111);
    chk("midrst_domain_rst", domain_rst_n, 0);
    chk("midrst_ready", cfg_ready, 0);
    chk("midrst_busy", busy, 1);
    adv(1);
    rst = 1'b0;
    adv(35);
    chk("reinit_ready_c35", cfg_ready, 0);
    adv(1);
    chk("reinit_ready_c36", cfg_ready, 1);
    chk("reinit_rst_c36", domain_rst_n, 4'hF);
    chk("reinit_div_c36", divisor, 16'h1111);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
